multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Moore-style FSM that sequences the multicycle datapath: IF (PC, IR), ID (register read, constant extension), EX (ULA), data memory, and register writeback.
- Decodes the instruction held in the IR and drives every enable and select for one instruction at a time.
- Handles the data-memory req/ack handshake with a timeout.
- Counts retired instructions and flags illegal opcodes and memory timeouts.

Parameters:
- RETIRED_W, 32, width of the retired-instruction counter.
- DMEM_TIMEOUT, 16, maximum cycles spent waiting for dmem_ack before an error is raised (must be 2..255).

Ports:
- clock  in  1  single system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- run  in  1  1 = may leave IDLE and fetch; sampled only in IDLE.
- instrucao  in  32  IR contents, valid from DECODE onward.
- dmem_ack  in  1  data memory completed the request this cycle.
- pc_write  out  1  PC <= PC+1 at the end of this cycle.
- ir_write  out  1  IR loads the instruction-memory output at the end of this cycle.
- reg_write  out  1  register C (instrucao[23:20]) written at the end of this cycle.
- alu_funct  out  5  ULA operation; equals instrucao[28:24] for R-class, 00000 (add) for memory address.
- alu_src_const  out  1  ULA B operand = extended constant.
- const_mode  out  2  00 sign-extend; 01 C=const16|(C&0xffff0000); 10 C=(const16<<16)|(C&0x0000ffff).
- dmem_req  out  1  data-memory request, held until ack.
- dmem_we  out  1  store qualifier, valid with dmem_req.
- wb_sel  out  1  0 = ULA result, 1 = memory data.
- state  out  3  current state encoding (debug).
- halted  out  1  sticky; HALT instruction executed.
- illegal  out  1  sticky; undefined class decoded.
- timeout  out  1  sticky; dmem_ack not received within DMEM_TIMEOUT.
- retired  out  RETIRED_W  count of completed instructions.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE (000); all outputs 0; retired=0; sticky flags cleared. Reset mid-instruction aborts the instruction; no write strobe may assert on the release edge.
- States: IDLE 000, FETCH 001, DECODE 010, EXECUTE 011, MEMORY 100, WRITEBACK 101, STOP 110.
- IDLE: go to FETCH when run=1.
- FETCH: assert ir_write=1 and pc_write=1 for exactly one cycle, then go to DECODE.
- DECODE: no strobes; classify instrucao[31:29]:
  - 001 R-class → EXECUTE.
  - 010 constant class → EXECUTE.
  - 100 memory class → EXECUTE.
  - instrucao==32'h0 NOP → retired+1, go to FETCH.
  - instrucao==32'hFFFFFFFF HALT → halted=1, go to STOP.
  - anything else → illegal=1, go to STOP.
- EXECUTE (1 cycle):
  - R-class: alu_funct=[28:24], alu_src_const=0.
  - Constant class: alu_src_const=1; const_mode=01 if [28:24]=01101, 10 if 01110, else 00.
  - Memory class: alu_funct=00000, alu_src_const=0 (address = A).
  - Next state: MEMORY for memory class, otherwise WRITEBACK.
- MEMORY:
  - Hold dmem_req=1 and dmem_we=instrucao[24] every cycle until dmem_ack=1.
  - On ack: store → retired+1, go to FETCH; load → WRITEBACK.
  - Wait counter reset on entry. If DMEM_TIMEOUT cycles elapse without ack: timeout=1, dmem_req drops, go to STOP.
  - Ack in the first MEMORY cycle gives zero wait.
- WRITEBACK: reg_write=1 for one cycle; wb_sel=1 for load, else 0; select outputs held from EXECUTE. retired+1, go to FETCH.
- STOP: terminal; all strobes 0; only reset exits.
- run is ignored outside IDLE; deasserting run mid-program does not stop execution.
- Latency, clocks from FETCH entry back to FETCH:
  - R / constant: 4.
  - NOP: 2.
  - Store: 4+w.
  - Load: 5+w, where w = extra ack-wait cycles.
- retired wraps modulo 2^RETIRED_W without a flag.
- Never more than one of pc_write / reg_write / dmem_req asserted in the same cycle.
- halted, illegal and timeout are mutually exclusive.

Test Plan:
- Reset, run=1, instrucao=32'h2012_3000 (R add, C=1, A=2, B=3) → states 001,010,011,101,001; reg_write only in 101, alu_funct=00000; retired=1.
- instrucao=32'h4D10_1234 (constant, funct 01101) → alu_src_const=1, const_mode=01 in EXECUTE; reg_write in WRITEBACK; 4 clocks per instruction.
- Load 32'h8012_0000, dmem_ack after 3 wait cycles → dmem_req high 4 cycles, dmem_we=0; wb_sel=1 with reg_write; 8 clocks total.
- Store 32'h8102_3000, ack in first MEMORY cycle → dmem_we=1, no reg_write, back to FETCH; retired+1.
- Load with dmem_ack held 0 → after 16 MEMORY cycles timeout=1, state=110, dmem_req=0; retired unchanged.
- instrucao=32'hE000_0001 → illegal=1, STOP. instrucao=32'hFFFF_FFFF → halted=1. Assert reset mid-MEMORY → IDLE immediately, flags and retired cleared.

Source files
------------

// File: rtl/multicycle_control.sv
// ----------------------------------------------------------------------------
// multicycle_control
//
// Moore-style control FSM for the multicycle datapath. One instruction at a
// time moves through fetch (PC, IR), decode, execute (ULA), optional data
// memory access and register writeback. The FSM drives every enable and
// select the datapath needs. It runs the data-memory req/ack handshake with
// a bounded wait and counts retired instructions.
//
// Ports:
//   clock          single system clock, rising-edge active
//   reset          asynchronous, active-low reset
//   run            start request, only looked at while IDLE
//   instrucao      IR contents, valid from DECODE onward
//   dmem_ack       data memory finished the pending request this cycle
//   pc_write       PC <= PC+1 at the end of this cycle
//   ir_write       IR loads the instruction-memory output at end of cycle
//   reg_write      register C (instrucao[23:20]) written at end of cycle
//   alu_funct      ULA operation select
//   alu_src_const  ULA B operand comes from the extended constant
//   const_mode     constant extension mode (00 sext, 01 low half, 10 high)
//   dmem_req       data-memory request, held until acknowledged
//   dmem_we        store qualifier, valid together with dmem_req
//   wb_sel         writeback source: 0 ULA result, 1 memory data
//   state          current state encoding, for debug visibility
//   halted         sticky, a HALT instruction was executed
//   illegal        sticky, an undefined instruction class was decoded
//   timeout        sticky, dmem_ack did not arrive within DMEM_TIMEOUT
//   retired        number of completed instructions, wraps silently
// ----------------------------------------------------------------------------
module multicycle_control #(
    parameter int RETIRED_W    = 32,
    parameter int DMEM_TIMEOUT = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 run,
    input  logic [31:0]          instrucao,
    input  logic                 dmem_ack,
    output logic                 pc_write,
    output logic                 ir_write,
    output logic                 reg_write,
    output logic [4:0]           alu_funct,
    output logic                 alu_src_const,
    output logic [1:0]           const_mode,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic                 wb_sel,
    output logic [2:0]           state,
    output logic                 halted,
    output logic                 illegal,
    output logic                 timeout,
    output logic [RETIRED_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'b000,
        S_FETCH     = 3'b001,
        S_DECODE    = 3'b010,
        S_EXECUTE   = 3'b011,
        S_MEMORY    = 3'b100,
        S_WRITEBACK = 3'b101,
        S_STOP      = 3'b110
    } state_t;

    typedef enum logic [1:0] {
        CLS_R     = 2'b00,
        CLS_CONST = 2'b01,
        CLS_MEM   = 2'b10,
        CLS_NONE  = 2'b11
    } class_t;

    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    // The last MEMORY cycle index that may still receive an ack. The wait
    // counter starts at zero on entry, so DMEM_TIMEOUT cycles are 0..N-1.
    localparam logic [7:0] WAIT_LAST = 8'(DMEM_TIMEOUT - 1);

    localparam logic [4:0] FUNCT_LOW_HALF  = 5'b01101;
    localparam logic [4:0] FUNCT_HIGH_HALF = 5'b01110;

    state_t     state_q;
    state_t     state_d;
    class_t     class_q;
    class_t     class_dec;
    logic [7:0] wait_cnt;

    logic       retire_now;
    logic       set_halt;
    logic       set_illegal;
    logic       set_timeout;

    // Instruction class from the top three opcode bits. The exact NOP and
    // HALT words are recognised separately in DECODE before this is used.
    always_comb begin
        class_dec = CLS_NONE;
        unique case (instrucao[31:29])
            3'b001:  class_dec = CLS_R;
            3'b010:  class_dec = CLS_CONST;
            3'b100:  class_dec = CLS_MEM;
            default: class_dec = CLS_NONE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The class is captured in DECODE. Later states then steer the selects
    // from a stable copy, even if the IR source changes under them.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            class_q <= CLS_NONE;
        end else if (state_q == S_DECODE) begin
            class_q <= class_dec;
        end
    end

    // The ack-wait counter restarts whenever the FSM is outside MEMORY. Each
    // visit to MEMORY therefore starts counting from zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_cnt <= 8'd0;
        end else if (state_q != S_MEMORY) begin
            wait_cnt <= 8'd0;
        end else begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // Retired counter and sticky error/halt flags. Only reset clears them.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            retired <= '0;
            halted  <= 1'b0;
            illegal <= 1'b0;
            timeout <= 1'b0;
        end else begin
            if (retire_now) begin
                retired <= retired + 1'b1;
            end
            if (set_halt) begin
                halted <= 1'b1;
            end
            if (set_illegal) begin
                illegal <= 1'b1;
            end
            if (set_timeout) begin
                timeout <= 1'b1;
            end
        end
    end

    // Next-state and Moore outputs. Strobes depend only on the current state.
    // The select lines also depend on the latched class and the IR fields.
    // EXECUTE, MEMORY and WRITEBACK all present the same selects, so the
    // datapath sees them steady for the whole instruction.
    always_comb begin
        state_d       = state_q;
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        alu_funct     = 5'b00000;
        alu_src_const = 1'b0;
        const_mode    = 2'b00;
        dmem_req      = 1'b0;
        dmem_we       = 1'b0;
        wb_sel        = 1'b0;
        retire_now    = 1'b0;
        set_halt      = 1'b0;
        set_illegal   = 1'b0;
        set_timeout   = 1'b0;

        if ((state_q == S_EXECUTE) || (state_q == S_MEMORY) ||
            (state_q == S_WRITEBACK)) begin
            unique case (class_q)
                CLS_R: begin
                    alu_funct = instrucao[28:24];
                end
                CLS_CONST: begin
                    alu_funct     = instrucao[28:24];
                    alu_src_const = 1'b1;
                    if (instrucao[28:24] == FUNCT_LOW_HALF) begin
                        const_mode = 2'b01;
                    end else if (instrucao[28:24] == FUNCT_HIGH_HALF) begin
                        const_mode = 2'b10;
                    end else begin
                        const_mode = 2'b00;
                    end
                end
                default: begin
                    // Memory address is A + 0, so the ULA performs an add.
                    alu_funct = 5'b00000;
                end
            endcase
        end

        unique case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                ir_write = 1'b1;
                pc_write = 1'b1;
                state_d  = S_DECODE;
            end

            S_DECODE: begin
                if (instrucao == NOP_WORD) begin
                    retire_now = 1'b1;
                    state_d    = S_FETCH;
                end else if (instrucao == HALT_WORD) begin
                    set_halt = 1'b1;
                    state_d  = S_STOP;
                end else if (class_dec == CLS_NONE) begin
                    set_illegal = 1'b1;
                    state_d     = S_STOP;
                end else begin
                    state_d = S_EXECUTE;
                end
            end

            S_EXECUTE: begin
                state_d = (class_q == CLS_MEM) ? S_MEMORY : S_WRITEBACK;
            end

            S_MEMORY: begin
                dmem_req = 1'b1;
                dmem_we  = instrucao[24];
                if (dmem_ack) begin
                    if (instrucao[24]) begin
                        // A store has nothing to write back, so it retires here.
                        retire_now = 1'b1;
                        state_d    = S_FETCH;
                    end else begin
                        state_d = S_WRITEBACK;
                    end
                end else if (wait_cnt == WAIT_LAST) begin
                    set_timeout = 1'b1;
                    state_d     = S_STOP;
                end
            end

            S_WRITEBACK: begin
                reg_write  = 1'b1;
                wb_sel     = (class_q == CLS_MEM);
                retire_now = 1'b1;
                state_d    = S_FETCH;
            end

            S_STOP: begin
                state_d = S_STOP;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// ----------------------------------------------------------------------------
// tb_multicycle_control
//
// Directed self-checking bench for multicycle_control. It walks through R,
// constant, load (with ack wait), store, NOP, memory timeout, illegal, HALT
// and a reset applied mid-MEMORY. Each expected value is worked out by hand
// from the instruction encodings.
// ----------------------------------------------------------------------------
module tb_multicycle_control;

    logic        clock;
    logic        reset;
    logic        run;
    logic [31:0] instrucao;
    logic        dmem_ack;
    logic        pc_write;
    logic        ir_write;
    logic        reg_write;
    logic [4:0]  alu_funct;
    logic        alu_src_const;
    logic [1:0]  const_mode;
    logic        dmem_req;
    logic        dmem_we;
    logic        wb_sel;
    logic [2:0]  state;
    logic        halted;
    logic        illegal;
    logic        timeout;
    logic [31:0] retired;

    int vectors;
    int miscompares;

    multicycle_control #(
        .RETIRED_W    (32),
        .DMEM_TIMEOUT (16)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .run           (run),
        .instrucao     (instrucao),
        .dmem_ack      (dmem_ack),
        .pc_write      (pc_write),
        .ir_write      (ir_write),
        .reg_write     (reg_write),
        .alu_funct     (alu_funct),
        .alu_src_const (alu_src_const),
        .const_mode    (const_mode),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .wb_sel        (wb_sel),
        .state         (state),
        .halted        (halted),
        .illegal       (illegal),
        .timeout       (timeout),
        .retired       (retired)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge and settle 1 time unit past it before sampling.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Hard stop so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=expired expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        run         = 1'b0;
        instrucao   = 32'h0;
        dmem_ack    = 1'b0;

        // Reset state.
        step();
        step();
        check_output("rst_state",   32'(state), 32'd0);
        check_output("rst_retired", retired,    32'd0);
        check_output("rst_flags",   {29'd0, halted, illegal, timeout}, 32'd0);
        check_output("rst_strobes", {28'd0, pc_write, ir_write, reg_write, dmem_req}, 32'd0);

        reset = 1'b1;
        step();
        check_output("idle_no_run", 32'(state), 32'd0);

        // R-class add C=1 A=2 B=3.
        instrucao = 32'h2012_3000;
        run       = 1'b1;
        step();
        check_output("r_fetch_state", 32'(state), 32'd1);
        check_output("r_fetch_strobes", {30'd0, ir_write, pc_write}, 32'd3);
        step();
        check_output("r_decode_state", 32'(state), 32'd2);
        check_output("r_decode_strobes", {28'd0, pc_write, ir_write, reg_write, dmem_req}, 32'd0);
        step();
        check_output("r_exec_state", 32'(state), 32'd3);
        check_output("r_exec_sel", {26'd0, alu_funct, alu_src_const}, 32'd0);
        check_output("r_exec_regwr", 32'(reg_write), 32'd0);
        step();
        check_output("r_wb_state", 32'(state), 32'd5);
        check_output("r_wb_regwr", {30'd0, reg_write, wb_sel}, 32'd2);
        step();
        check_output("r_back_fetch", 32'(state), 32'd1);
        check_output("r_retired", retired, 32'd1);

        // Constant class, funct 01101. run dropped: must be ignored.
        instrucao = 32'h4D10_1234;
        run       = 1'b0;
        step();
        step();
        check_output("c_exec_state", 32'(state), 32'd3);
        check_output("c_exec_sel", {29'd0, alu_src_const, const_mode}, 32'd5);
        step();
        check_output("c_wb_regwr", 32'(reg_write), 32'd1);
        check_output("c_wb_const_mode", 32'(const_mode), 32'd1);
        step();
        check_output("c_back_fetch", 32'(state), 32'd1);
        check_output("c_retired", retired, 32'd2);

        // Load, ack arrives in the fourth MEMORY cycle.
        instrucao = 32'h8012_0000;
        step();
        step();
        check_output("ld_exec_sel", {26'd0, alu_funct, alu_src_const}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check_output("ld_mem_state", 32'(state), 32'd4);
            check_output("ld_mem_req_we", {30'd0, dmem_req, dmem_we}, 32'd2);
            check_output("ld_mem_regwr", 32'(reg_write), 32'd0);
        end
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        check_output("ld_wb_state", 32'(state), 32'd5);
        check_output("ld_wb_regwr_sel", {29'd0, reg_write, wb_sel, dmem_req}, 32'd6);
        check_output("ld_retired_before", retired, 32'd2);
        step();
        check_output("ld_back_fetch", 32'(state), 32'd1);
        check_output("ld_retired", retired, 32'd3);

        // Store, ack in the first MEMORY cycle.
        instrucao = 32'h8102_3000;
        step();
        step();
        step();
        check_output("st_mem_state", 32'(state), 32'd4);
        check_output("st_mem_req_we", {30'd0, dmem_req, dmem_we}, 32'd3);
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        check_output("st_back_fetch", 32'(state), 32'd1);
        check_output("st_no_regwr", 32'(reg_write), 32'd0);
        check_output("st_retired", retired, 32'd4);

        // NOP takes two clocks.
        instrucao = 32'h0000_0000;
        step();
        check_output("nop_decode", 32'(state), 32'd2);
        step();
        check_output("nop_back_fetch", 32'(state), 32'd1);
        check_output("nop_retired", retired, 32'd5);

        // Load with no ack: 16 MEMORY cycles, then STOP with timeout.
        instrucao = 32'h8012_0000;
        step();
        step();
        step();
        check_output("to_mem_first", 32'(state), 32'd4);
        for (int i = 0; i < 15; i++) begin
            step();
        end
        check_output("to_mem_last", 32'(state), 32'd4);
        check_output("to_mem_last_req", 32'(dmem_req), 32'd1);
        check_output("to_no_flag_yet", 32'(timeout), 32'd0);
        step();
        check_output("to_stop_state", 32'(state), 32'd6);
        check_output("to_flags", {29'd0, halted, illegal, timeout}, 32'd1);
        check_output("to_req_drop", 32'(dmem_req), 32'd0);
        check_output("to_retired", retired, 32'd5);
        step();
        check_output("to_stop_stays", 32'(state), 32'd6);

        // Asynchronous reset between edges clears everything immediately.
        #2;
        reset = 1'b0;
        #1;
        check_output("arst_state", 32'(state), 32'd0);
        check_output("arst_flags", {29'd0, halted, illegal, timeout}, 32'd0);
        check_output("arst_retired", retired, 32'd0);

        // Illegal class 111.
        step();
        reset     = 1'b1;
        run       = 1'b1;
        instrucao = 32'hE000_0001;
        step();
        step();
        step();
        check_output("ill_stop_state", 32'(state), 32'd6);
        check_output("ill_flags", {29'd0, halted, illegal, timeout}, 32'd2);
        step();
        check_output("ill_stop_strobes", {28'd0, pc_write, ir_write, reg_write, dmem_req}, 32'd0);
        check_output("ill_retired", retired, 32'd0);

        // HALT.
        reset = 1'b0;
        step();
        reset     = 1'b1;
        instrucao = 32'hFFFF_FFFF;
        step();
        step();
        step();
        check_output("halt_stop_state", 32'(state), 32'd6);
        check_output("halt_flags", {29'd0, halted, illegal, timeout}, 32'd4);

        // Reset mid-MEMORY after one retired R instruction.
        reset = 1'b0;
        step();
        reset     = 1'b1;
        instrucao = 32'h2012_3000;
        step();
        step();
        step();
        step();
        instrucao = 32'h8012_0000;
        step();
        check_output("mr_retired_pre", retired, 32'd1);
        step();
        step();
        step();
        check_output("mr_in_memory", 32'(state), 32'd4);
        #3;
        reset = 1'b0;
        #1;
        check_output("mr_state", 32'(state), 32'd0);
        check_output("mr_retired", retired, 32'd0);
        check_output("mr_req", 32'(dmem_req), 32'd0);
        run = 1'b0;
        step();
        reset = 1'b1;
        check_output("mr_release_strobes", {28'd0, pc_write, ir_write, reg_write, dmem_req}, 32'd0);
        step();
        check_output("mr_release_idle", 32'(state), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
